// File: rtl/ttl_decrement_update.sv
// IPv4 TTL decrement stage: patches the header checksum incrementally and punts TTL-expired packets to the paired CPU port.
// Optional macro TTL_EXPIRED_DROP_EN: discard TTL-expired packets instead of punting them.
module ttl_decrement_update #(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXI_DATA_WIDTH   = 32,
    parameter int SRC_PORT_POS         = 16,
    parameter int DST_PORT_POS         = 24,
    parameter int FIFO_DEPTH_BITS      = 4
) (
    input  logic                                AXI_ACLK,
    input  logic                                AXI_RESETN,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]      S_AXIS_TDATA,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    S_AXIS_TSTRB,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     S_AXIS_TUSER,
    input  logic                                S_AXIS_TVALID,
    output logic                                S_AXIS_TREADY,
    input  logic                                S_AXIS_TLAST,

    output logic [C_M_AXIS_DATA_WIDTH-1:0]      M_AXIS_TDATA,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]    M_AXIS_TSTRB,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]     M_AXIS_TUSER,
    output logic                                M_AXIS_TVALID,
    input  logic                                M_AXIS_TREADY,
    output logic                                M_AXIS_TLAST,

    input  logic [C_S_AXI_DATA_WIDTH-1:0]       reset,
    output logic [31:0]                         ttl_expired_count,
    output logic [31:0]                         forwarded_count
);

    localparam int DW    = C_S_AXIS_DATA_WIDTH;
    localparam int SW    = C_S_AXIS_DATA_WIDTH / 8;
    localparam int UW    = C_S_AXIS_TUSER_WIDTH;
    localparam int FW    = 1 + UW + SW + DW;
    localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
    localparam logic [FIFO_DEPTH_BITS:0] NEARLY_FULL_LVL = (FIFO_DEPTH_BITS + 1)'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_HEADER  = 2'd0,
        S_PAYLOAD = 2'd1
`ifdef TTL_EXPIRED_DROP_EN
        , S_DROP  = 2'd2
`endif
    } state_t;

    // 16-bit ones-complement add; the second fold covers a carry produced by the first.
    function automatic logic [15:0] oc_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        s = {1'b0, s[15:0]} + {16'b0, s[16]};
        s = {1'b0, s[15:0]} + {16'b0, s[16]};
        return s[15:0];
    endfunction

    // ------------------------------------------------------------------
    // Input fallthrough FIFO
    // ------------------------------------------------------------------
    logic [FW-1:0]              fifo_mem [DEPTH];
    logic [FIFO_DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_DEPTH_BITS:0]   count_q, count_d;
    logic                       fifo_wr, fifo_pop, fifo_empty, nearly_full;

    logic                       head_last;
    logic [UW-1:0]              head_user;
    logic [SW-1:0]              head_strb;
    logic [DW-1:0]              head_data;

    assign fifo_empty    = (count_q == '0);
    assign nearly_full   = (count_q >= NEARLY_FULL_LVL);
    assign S_AXIS_TREADY = AXI_RESETN && !nearly_full;
    assign fifo_wr       = S_AXIS_TVALID && S_AXIS_TREADY;
    assign {head_last, head_user, head_strb, head_data} = fifo_mem[rd_ptr_q];

    always_ff @(posedge AXI_ACLK) begin
        if (fifo_wr) begin
            fifo_mem[wr_ptr_q] <= {S_AXIS_TLAST, S_AXIS_TUSER, S_AXIS_TSTRB, S_AXIS_TDATA};
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (fifo_wr) wr_ptr_d = wr_ptr_q + 1'b1;
        if (fifo_pop) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({fifo_wr, fifo_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Header field extraction and checksum patch
    // ------------------------------------------------------------------
    logic        is_ipv4, ttl_expired;
    logic [7:0]  ttl, proto, ttl_dec;
    logic [15:0] hc, hc_partial, hc_new;

    assign is_ipv4     = (head_data[159:144] == 16'h0800);
    assign ttl         = head_data[79:72];
    assign proto       = head_data[71:64];
    assign hc          = head_data[63:48];
    assign ttl_expired = (ttl <= 8'd1);
    assign ttl_dec     = ttl - 8'd1;
    assign hc_partial  = oc_add(~hc, ~{ttl, proto});
    assign hc_new      = ~oc_add(hc_partial, {ttl_dec, proto});

    // ------------------------------------------------------------------
    // Packet FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    state_t        state_q, state_d;
    logic [DW-1:0] beat_data;
    logic [UW-1:0] beat_user;
    logic          fwd_hit, exp_hit, drop_beat;

    always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
        if (!AXI_RESETN) state_q <= S_HEADER;
        else             state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_HEADER: begin
                if (fifo_pop && !head_last) begin
`ifdef TTL_EXPIRED_DROP_EN
                    if (is_ipv4 && ttl_expired) state_d = S_DROP;
                    else                        state_d = S_PAYLOAD;
`else
                    state_d = S_PAYLOAD;
`endif
                end
            end
            S_PAYLOAD: begin
                if (fifo_pop && head_last) state_d = S_HEADER;
            end
`ifdef TTL_EXPIRED_DROP_EN
            S_DROP: begin
                if (fifo_pop && head_last) state_d = S_HEADER;
            end
`endif
            default: state_d = S_HEADER;
        endcase
    end

    always_comb begin
        beat_data = head_data;
        beat_user = head_user;
        fwd_hit   = 1'b0;
        exp_hit   = 1'b0;
        drop_beat = 1'b0;
        if (state_q == S_HEADER && is_ipv4) begin
            if (!ttl_expired) begin
                beat_data[79:72] = ttl_dec;
                beat_data[63:48] = hc_new;
                fwd_hit          = 1'b1;
            end else begin
                exp_hit = 1'b1;
`ifdef TTL_EXPIRED_DROP_EN
                drop_beat = 1'b1;
`else
                // Odd one-hot bits are CPU ports, so the ingress port's CPU twin is one bit up.
                beat_user[DST_PORT_POS +: 8] = head_user[SRC_PORT_POS +: 8] << 1;
`endif
            end
        end
`ifdef TTL_EXPIRED_DROP_EN
        if (state_q == S_DROP) drop_beat = 1'b1;
`endif
    end

    // ------------------------------------------------------------------
    // Output register stage
    // ------------------------------------------------------------------
    logic          out_valid_q, out_valid_d;
    logic          out_last_q, out_last_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic [SW-1:0] out_strb_q, out_strb_d;
    logic [UW-1:0] out_user_q, out_user_d;
    logic          out_load, can_load;

    // Dropped beats drain regardless of downstream backpressure.
    assign can_load = !out_valid_q || M_AXIS_TREADY;
    assign fifo_pop = !fifo_empty && (drop_beat || can_load);
    assign out_load = fifo_pop && !drop_beat;

    always_comb begin
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        out_strb_d  = out_strb_q;
        out_user_d  = out_user_q;
        if (out_load) begin
            out_valid_d = 1'b1;
            out_last_d  = head_last;
            out_data_d  = beat_data;
            out_strb_d  = head_strb;
            out_user_d  = beat_user;
        end else if (M_AXIS_TREADY) begin
            out_valid_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Counters: clear has priority over a same-cycle increment
    // ------------------------------------------------------------------
    logic [31:0] fwd_cnt_q, fwd_cnt_d;
    logic [31:0] exp_cnt_q, exp_cnt_d;
    logic        cnt_clear;

    assign cnt_clear = (reset == C_S_AXI_DATA_WIDTH'(1));

    always_comb begin
        fwd_cnt_d = fwd_cnt_q;
        exp_cnt_d = exp_cnt_q;
        if (cnt_clear) begin
            fwd_cnt_d = '0;
            exp_cnt_d = '0;
        end else begin
            if (fifo_pop && fwd_hit) fwd_cnt_d = fwd_cnt_q + 32'd1;
            if (fifo_pop && exp_hit) exp_cnt_d = exp_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
        if (!AXI_RESETN) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            out_strb_q  <= '0;
            out_user_q  <= '0;
            fwd_cnt_q   <= '0;
            exp_cnt_q   <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            out_strb_q  <= out_strb_d;
            out_user_q  <= out_user_d;
            fwd_cnt_q   <= fwd_cnt_d;
            exp_cnt_q   <= exp_cnt_d;
        end
    end

    assign M_AXIS_TVALID     = out_valid_q;
    assign M_AXIS_TLAST      = out_last_q;
    assign M_AXIS_TDATA      = out_data_q;
    assign M_AXIS_TSTRB      = out_strb_q;
    assign M_AXIS_TUSER      = out_user_q;
    assign forwarded_count   = fwd_cnt_q;
    assign ttl_expired_count = exp_cnt_q;

endmodule

// File: tb/tb_ttl_decrement_update.sv
// Randomized self-checking bench for ttl_decrement_update against a packet-level reference model.
// Honours TTL_EXPIRED_DROP_EN when the bundle is compiled with it.
module tb_ttl_decrement_update;

    typedef struct packed {
        logic         last;
        logic [127:0] user;
        logic [31:0]  strb;
        logic [255:0] data;
    } beat_t;

`ifdef TTL_EXPIRED_DROP_EN
    localparam bit DROP_MODE = 1'b1;
`else
    localparam bit DROP_MODE = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [255:0] s_tdata = '0;
    logic [31:0]  s_tstrb = '0;
    logic [127:0] s_tuser = '0;
    logic         s_tvalid = 1'b0;
    logic         s_tready;
    logic         s_tlast = 1'b0;
    logic [255:0] m_tdata;
    logic [31:0]  m_tstrb;
    logic [127:0] m_tuser;
    logic         m_tvalid;
    logic         m_tready = 1'b1;
    logic         m_tlast;
    logic [31:0]  ctr_clear = '0;
    logic [31:0]  ttl_expired_count, forwarded_count;

    beat_t in_q[$], exp_q[$], mon_q[$];
    int    exp_fwd = 0, exp_exp = 0;
    int    n_cmp = 0, n_bad = 0;

    ttl_decrement_update dut (
        .AXI_ACLK(clk), .AXI_RESETN(rst_n),
        .S_AXIS_TDATA(s_tdata), .S_AXIS_TSTRB(s_tstrb), .S_AXIS_TUSER(s_tuser),
        .S_AXIS_TVALID(s_tvalid), .S_AXIS_TREADY(s_tready), .S_AXIS_TLAST(s_tlast),
        .M_AXIS_TDATA(m_tdata), .M_AXIS_TSTRB(m_tstrb), .M_AXIS_TUSER(m_tuser),
        .M_AXIS_TVALID(m_tvalid), .M_AXIS_TREADY(m_tready), .M_AXIS_TLAST(m_tlast),
        .reset(ctr_clear), .ttl_expired_count(ttl_expired_count), .forwarded_count(forwarded_count)
    );

    always #5 clk = ~clk;

    // Inputs change only at posedge+1, so a negedge handshake sample predicts the next transfer.
    always @(negedge clk) begin
        if (rst_n && m_tvalid && m_tready) mon_q.push_back({m_tlast, m_tuser, m_tstrb, m_tdata});
    end

    // Reference header rewrite: checksum from a wide sum folded until it fits 16 bits.
    function automatic beat_t model_hdr(input beat_t b, output int fwd, output int expd);
        beat_t       r;
        logic [7:0]  t, p;
        logic [15:0] nhc, nm, mn;
        logic [31:0] s;
        r = b; fwd = 0; expd = 0;
        t = b.data[79:72];
        p = b.data[71:64];
        if (b.data[159:144] == 16'h0800) begin
            if (t > 8'd1) begin
                nhc = ~b.data[63:48];
                nm  = ~{t, p};
                mn  = {t - 8'd1, p};
                s   = {16'b0, nhc} + {16'b0, nm} + {16'b0, mn};
                while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
                r.data[63:48] = ~s[15:0];
                r.data[79:72] = t - 8'd1;
                fwd = 1;
            end else begin
                expd = 1;
                r.user[31:24] = {b.user[22:16], 1'b0};
            end
        end
        return r;
    endfunction

    task automatic make_pkt(input logic [15:0] etype, input logic [7:0] ttl, input logic [7:0] proto,
                            input logic [15:0] hc, input logic [7:0] src, input int nbeats);
        beat_t b, e;
        int    fwd, expd;
        bit    keep;
        keep = 1'b1;
        for (int i = 0; i < nbeats; i++) begin
            for (int k = 0; k < 8; k++) b.data[k*32 +: 32] = $urandom;
            b.strb = $urandom;
            b.user = {$urandom, $urandom, $urandom, $urandom};
            b.last = (i == nbeats - 1);
            e = b;
            if (i == 0) begin
                b.data[159:144] = etype;
                b.data[79:72]   = ttl;
                b.data[71:64]   = proto;
                b.data[63:48]   = hc;
                b.user[23:16]   = src;
                e = model_hdr(b, fwd, expd);
                exp_fwd += fwd;
                exp_exp += expd;
                keep = !(expd == 1 && DROP_MODE);
            end
            in_q.push_back(b);
            if (keep) exp_q.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input beat_t b);
        s_tdata = b.data; s_tstrb = b.strb; s_tuser = b.user; s_tlast = b.last;
        s_tvalid = 1'b1;
    endtask

    task automatic drive_in_q(output bit ok);
        beat_t b;
        int    guard;
        ok = 1'b1;
        while (in_q.size() > 0) begin
            b = in_q.pop_front();
            drive_beat(b);
            guard = 0;
            @(negedge clk);
            while (!s_tready && guard < 2000) begin
                guard++;
                @(negedge clk);
            end
            if (!s_tready) begin
                ok = 1'b0;
                in_q.delete();
                s_tvalid = 1'b0;
                return;
            end
            tick();
        end
        s_tvalid = 1'b0;
    endtask

    task automatic wait_out(input int n);
        int guard = 0;
        while (mon_q.size() < n && guard < 20000) begin
            tick();
            guard++;
        end
        repeat (8) tick();
    endtask

    task automatic new_scenario();
        in_q.delete(); exp_q.delete(); mon_q.delete();
        ctr_clear = 32'd1;
        tick();
        ctr_clear = 32'd0;
        exp_fwd = 0; exp_exp = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        n_cmp++;
        if ({m_tvalid, m_tlast, m_tdata, m_tstrb, m_tuser} !== '0) begin
            n_bad++; $display("FAIL reset_outputs: got valid=%b data=%h, want all zero", m_tvalid, m_tdata);
        end
        n_cmp++;
        if (s_tready !== 1'b0) begin
            n_bad++; $display("FAIL reset_s_tready: got %b want 0", s_tready);
        end
        n_cmp++;
        if (forwarded_count !== 32'd0 || ttl_expired_count !== 32'd0) begin
            n_bad++; $display("FAIL reset_counters: got fwd=%0d exp=%0d want 0/0", forwarded_count, ttl_expired_count);
        end
        tick();
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        n_cmp++;
        if (s_tready !== 1'b1) begin
            n_bad++; $display("FAIL post_reset_s_tready: got %b want 1", s_tready);
        end
        $display("test_reset done");
    endtask

    task automatic test_ipv4_forward();
        beat_t b;
        new_scenario();
        m_tready = 1'b1;
        make_pkt(16'h0800, 8'h40, 8'h11, 16'hB861, 8'h01, 3);
        b = in_q.pop_front(); drive_beat(b); tick();
        @(negedge clk);
        n_cmp++;
        if (m_tvalid !== 1'b0) begin
            n_bad++; $display("FAIL latency_cycle1: got tvalid=%b want 0", m_tvalid);
        end
        b = in_q.pop_front(); drive_beat(b); tick();
        @(negedge clk);
        n_cmp++;
        if (m_tvalid !== 1'b1) begin
            n_bad++; $display("FAIL latency_cycle2: got tvalid=%b want 1", m_tvalid);
        end
        b = in_q.pop_front(); drive_beat(b); tick();
        s_tvalid = 1'b0;
        wait_out(exp_q.size());
        n_cmp++;
        if (mon_q.size() !== exp_q.size()) begin
            n_bad++; $display("FAIL fwd_beat_count: got %0d want %0d", mon_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
            n_cmp++;
            if (mon_q[i] !== exp_q[i]) begin
                n_bad++; $display("FAIL fwd_beat %0d: got data=%h user=%h, want data=%h user=%h", i, mon_q[i].data, mon_q[i].user, exp_q[i].data, exp_q[i].user);
            end
        end
        if (mon_q.size() > 0) begin
            n_cmp++;
            if (mon_q[0].data[79:72] !== 8'h3F || mon_q[0].data[63:48] !== 16'hB961) begin
                n_bad++; $display("FAIL fwd_fields: got ttl=%h hc=%h want ttl=3f hc=b961", mon_q[0].data[79:72], mon_q[0].data[63:48]);
            end
        end
        n_cmp++;
        if (forwarded_count !== 32'd1 || ttl_expired_count !== 32'd0) begin
            n_bad++; $display("FAIL fwd_counters: got fwd=%0d exp=%0d want 1/0", forwarded_count, ttl_expired_count);
        end
        $display("test_ipv4_forward done: %0d beats", mon_q.size());
    endtask

    task automatic test_ttl_expired();
        bit ok;
        new_scenario();
        make_pkt(16'h0800, 8'h01, 8'h06, 16'($urandom), 8'h04, 2);
        drive_in_q(ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL exp_drive: got input stall timeout want accepted"); end
        wait_out(exp_q.size());
        n_cmp++;
        if (mon_q.size() !== exp_q.size()) begin
            n_bad++; $display("FAIL exp_beat_count: got %0d want %0d", mon_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
            n_cmp++;
            if (mon_q[i] !== exp_q[i]) begin
                n_bad++; $display("FAIL exp_beat %0d: got data=%h user=%h, want data=%h user=%h", i, mon_q[i].data, mon_q[i].user, exp_q[i].data, exp_q[i].user);
            end
        end
        if (!DROP_MODE && mon_q.size() > 0) begin
            n_cmp++;
            if (mon_q[0].user[31:24] !== 8'h08) begin
                n_bad++; $display("FAIL exp_dst_port: got %h want 08", mon_q[0].user[31:24]);
            end
        end
        n_cmp++;
        if (ttl_expired_count !== 32'd1 || forwarded_count !== 32'd0) begin
            n_bad++; $display("FAIL exp_counters: got exp=%0d fwd=%0d want 1/0", ttl_expired_count, forwarded_count);
        end
        $display("test_ttl_expired done: %0d beats out", mon_q.size());
    endtask

    task automatic test_checksum_wrap();
        bit ok;
        new_scenario();
        // The ones-complement formula turns ~HC + ~m + m' = 0xFFFF into HC' = 0x0000 here.
        make_pkt(16'h0800, 8'h02, 8'h06, 16'hFEFF, 8'h10, 1);
        drive_in_q(ok);
        wait_out(exp_q.size());
        n_cmp++;
        if (!ok || mon_q.size() !== 1) begin
            n_bad++; $display("FAIL wrap_beat_count: got %0d want 1", mon_q.size());
        end else begin
            n_cmp++;
            if (mon_q[0] !== exp_q[0]) begin
                n_bad++; $display("FAIL wrap_beat: got hc=%h ttl=%h want hc=%h ttl=%h", mon_q[0].data[63:48], mon_q[0].data[79:72], exp_q[0].data[63:48], exp_q[0].data[79:72]);
            end
            n_cmp++;
            if (mon_q[0].data[79:72] !== 8'h01) begin
                n_bad++; $display("FAIL wrap_ttl: got %h want 01", mon_q[0].data[79:72]);
            end
        end
        $display("test_checksum_wrap done");
    endtask

    task automatic test_arp();
        bit ok;
        new_scenario();
        make_pkt(16'h0806, 8'h01, 8'h00, 16'($urandom), 8'h01, 1);
        drive_in_q(ok);
        wait_out(exp_q.size());
        n_cmp++;
        if (!ok || mon_q.size() !== 1) begin
            n_bad++; $display("FAIL arp_beat_count: got %0d want 1", mon_q.size());
        end else begin
            n_cmp++;
            if (mon_q[0] !== exp_q[0]) begin
                n_bad++; $display("FAIL arp_beat: got data=%h want data=%h", mon_q[0].data, exp_q[0].data);
            end
        end
        n_cmp++;
        if (forwarded_count !== 32'd0 || ttl_expired_count !== 32'd0) begin
            n_bad++; $display("FAIL arp_counters: got fwd=%0d exp=%0d want 0/0", forwarded_count, ttl_expired_count);
        end
        mon_q.delete(); exp_q.delete();
        make_pkt(16'h0800, 8'h20, 8'h11, 16'($urandom), 8'h02, 2);
        drive_in_q(ok);
        wait_out(exp_q.size());
        n_cmp++;
        if (mon_q.size() !== 2) begin
            n_bad++; $display("FAIL arp_next_count: got %0d want 2", mon_q.size());
        end else begin
            n_cmp++;
            if (mon_q[0] !== exp_q[0] || mon_q[1] !== exp_q[1]) begin
                n_bad++; $display("FAIL arp_next_hdr: got ttl=%h hc=%h want ttl=%h hc=%h", mon_q[0].data[79:72], mon_q[0].data[63:48], exp_q[0].data[79:72], exp_q[0].data[63:48]);
            end
        end
        n_cmp++;
        if (forwarded_count !== 32'd1) begin
            n_bad++; $display("FAIL arp_next_fwd: got %0d want 1", forwarded_count);
        end
        $display("test_arp done");
    endtask

    task automatic test_back_to_back();
        bit ok;
        int total;
        new_scenario();
        for (int p = 0; p < 100; p++) begin
            make_pkt(16'h0800, 8'($urandom_range(2, 255)), 8'($urandom), 16'($urandom), 8'(1 << $urandom_range(0, 7)), 4);
        end
        total = exp_q.size();
        fork
            drive_in_q(ok);
            begin
                bit    stalled;
                beat_t held;
                int    cyc;
                stalled = 1'b0; cyc = 0;
                while (mon_q.size() < total && cyc < 20000) begin
                    @(negedge clk);
                    if (stalled) begin
                        n_cmp++;
                        if (!m_tvalid || {m_tlast, m_tuser, m_tstrb, m_tdata} !== held) begin
                            n_bad++; $display("FAIL stall_hold: got valid=%b data=%h, want valid=1 data=%h", m_tvalid, m_tdata, held.data);
                        end
                    end
                    stalled = m_tvalid && !m_tready;
                    held    = {m_tlast, m_tuser, m_tstrb, m_tdata};
                    tick();
                    m_tready = 1'($urandom_range(0, 1));
                    cyc++;
                end
                m_tready = 1'b1;
            end
        join
        wait_out(total);
        n_cmp++;
        if (!ok || mon_q.size() !== total) begin
            n_bad++; $display("FAIL b2b_beat_count: got %0d want %0d", mon_q.size(), total);
        end
        for (int i = 0; i < total && i < mon_q.size(); i++) begin
            n_cmp++;
            if (mon_q[i] !== exp_q[i]) begin
                n_bad++; $display("FAIL b2b_beat %0d: got data=%h, want data=%h", i, mon_q[i].data, exp_q[i].data);
            end
        end
        n_cmp++;
        if (forwarded_count !== 32'd100 || ttl_expired_count !== 32'd0) begin
            n_bad++; $display("FAIL b2b_counters: got fwd=%0d exp=%0d want 100/0", forwarded_count, ttl_expired_count);
        end
        $display("test_back_to_back done: %0d beats", mon_q.size());
    endtask

    task automatic test_random_mix();
        bit ok;
        int total;
        logic [15:0] et;
        new_scenario();
        for (int p = 0; p < 40; p++) begin
            case ($urandom_range(0, 3))
                0:       et = 16'h86DD;
                1:       et = 16'h0806;
                default: et = 16'h0800;
            endcase
            make_pkt(et, ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 2)) : 8'($urandom),
                     8'($urandom), 16'($urandom), 8'(1 << $urandom_range(0, 7)), $urandom_range(1, 4));
        end
        total = exp_q.size();
        fork
            drive_in_q(ok);
            begin
                int cyc = 0;
                while (mon_q.size() < total && cyc < 20000) begin
                    tick();
                    m_tready = 1'($urandom_range(0, 1));
                    cyc++;
                end
                m_tready = 1'b1;
            end
        join
        wait_out(total);
        n_cmp++;
        if (!ok || mon_q.size() !== total) begin
            n_bad++; $display("FAIL mix_beat_count: got %0d want %0d", mon_q.size(), total);
        end
        for (int i = 0; i < total && i < mon_q.size(); i++) begin
            n_cmp++;
            if (mon_q[i] !== exp_q[i]) begin
                n_bad++; $display("FAIL mix_beat %0d: got data=%h user=%h, want data=%h user=%h", i, mon_q[i].data, mon_q[i].user, exp_q[i].data, exp_q[i].user);
            end
        end
        n_cmp++;
        if (forwarded_count !== 32'(exp_fwd) || ttl_expired_count !== 32'(exp_exp)) begin
            n_bad++; $display("FAIL mix_counters: got fwd=%0d exp=%0d want %0d/%0d", forwarded_count, ttl_expired_count, exp_fwd, exp_exp);
        end
        $display("test_random_mix done: %0d beats, fwd=%0d exp=%0d", mon_q.size(), exp_fwd, exp_exp);
    endtask

    task automatic test_reset_mid_packet();
        beat_t b;
        bit    ok;
        new_scenario();
        m_tready = 1'b0;
        make_pkt(16'h0800, 8'h30, 8'h11, 16'($urandom), 8'h01, 4);
        for (int i = 0; i < 2; i++) begin
            b = in_q.pop_front(); drive_beat(b); tick();
        end
        s_tvalid = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if (forwarded_count !== 32'd1 || m_tvalid !== 1'b1) begin
            n_bad++; $display("FAIL pre_reset: got fwd=%0d valid=%b want 1/1", forwarded_count, m_tvalid);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (m_tvalid !== 1'b0 || m_tdata !== '0 || m_tuser !== '0 || forwarded_count !== 32'd0 || s_tready !== 1'b0) begin
            n_bad++; $display("FAIL async_reset: got valid=%b fwd=%0d s_ready=%b want 0/0/0", m_tvalid, forwarded_count, s_tready);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        in_q.delete(); exp_q.delete(); mon_q.delete();
        exp_fwd = 0; exp_exp = 0;
        m_tready = 1'b1;
        make_pkt(16'h0800, 8'h05, 8'h06, 16'($urandom), 8'h20, 3);
        drive_in_q(ok);
        wait_out(exp_q.size());
        n_cmp++;
        if (!ok || mon_q.size() !== 3) begin
            n_bad++; $display("FAIL post_reset_count: got %0d want 3", mon_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
            n_cmp++;
            if (mon_q[i] !== exp_q[i]) begin
                n_bad++; $display("FAIL post_reset_beat %0d: got data=%h want data=%h", i, mon_q[i].data, exp_q[i].data);
            end
        end
        n_cmp++;
        if (forwarded_count !== 32'd1) begin
            n_bad++; $display("FAIL post_reset_fwd: got %0d want 1", forwarded_count);
        end
        // Header is accepted at the first edge and loaded (counted) at the second, where the clear also lands.
        exp_q.delete(); mon_q.delete();
        make_pkt(16'h0800, 8'h10, 8'h11, 16'($urandom), 8'h01, 1);
        b = in_q.pop_front(); drive_beat(b); tick();
        s_tvalid = 1'b0;
        ctr_clear = 32'd1;
        tick();
        ctr_clear = 32'd0;
        exp_fwd = 0; exp_exp = 0;
        wait_out(1);
        n_cmp++;
        if (mon_q.size() !== 1 || mon_q[0] !== exp_q[0]) begin
            n_bad++; $display("FAIL clear_beat: got %0d beats want 1 matching", mon_q.size());
        end
        n_cmp++;
        if (forwarded_count !== 32'd0) begin
            n_bad++; $display("FAIL clear_wins: got fwd=%0d want 0", forwarded_count);
        end
        mon_q.delete(); exp_q.delete();
        make_pkt(16'h0800, 8'h80, 8'h11, 16'($urandom), 8'h01, 2);
        drive_in_q(ok);
        wait_out(exp_q.size());
        n_cmp++;
        if (forwarded_count !== 32'd1 || mon_q.size() !== 2) begin
            n_bad++; $display("FAIL after_clear: got fwd=%0d beats=%0d want 1/2", forwarded_count, mon_q.size());
        end
        $display("test_reset_mid_packet done");
    endtask

    initial begin
        test_reset();
        test_ipv4_forward();
        test_ttl_expired();
        test_checksum_wrap();
        test_arp();
        test_back_to_back();
        test_random_mix();
        test_reset_mid_packet();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
